// File: rtl/rmii_arb_pkg.sv
// rmii_arb_pkg: shared types and defaults for the RMII TX frame arbiter.
// Holds the arbiter state encoding, default limits and counter width.
package rmii_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } arb_state_t;

  localparam int DEF_MAX_BYTES = 1536;
  localparam int DEF_GAP_CYC   = 2;
  localparam int BYTE_CNT_W    = 11;

endpackage

// File: rtl/rmii_tx_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: req (request vector), last (previous winner) -> pick (one-hot), valid.
module rr_pick #(
  parameter int N_SRC = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_SRC-1:0] pick,
  output logic             valid
);

  // Search last+1, last+2, ... wrapping; first hit wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!valid && req[i] &&
            ((int'(last) + k) % N_SRC == i)) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rmii_tx_frame_arbiter.sv
// rmii_tx_frame_arbiter: frame-granular round-robin share of one RMII_TX.
// Ports: REF_CLK/arst_n; src_* FIFO read sides; tx_fifo_* to RMII_TX; grant, busy, err_overlong.
module rmii_tx_frame_arbiter
  import rmii_arb_pkg::*;
#(
  parameter int N_SRC     = 3,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic                    REF_CLK,
  input  logic                    arst_n,
  input  logic [N_SRC*DATA_W-1:0] src_dout,
  input  logic [N_SRC-1:0]        src_empty,
  input  logic [N_SRC-1:0]        src_aempty,
  input  logic [N_SRC-1:0]        src_eod,
  output logic [N_SRC-1:0]        src_rden,
  output logic [DATA_W-1:0]       tx_fifo_dout,
  output logic                    tx_fifo_empty,
  output logic                    tx_fifo_aempty,
  output logic                    tx_fifo_eod,
  input  logic                    tx_fifo_rden,
  output logic [N_SRC-1:0]        grant,
  output logic                    busy,
  output logic                    err_overlong
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW_MIN = $clog2(MAX_BYTES + 1);
  localparam int CNT_W =
    (CW_MIN > BYTE_CNT_W) ? CW_MIN : BYTE_CNT_W;
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(MAX_BYTES - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_CYC);

  arb_state_t         r_state;
  logic [N_SRC-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [3:0]         r_gap_cnt;
  logic               r_busy;
  logic               r_err;

  logic [N_SRC-1:0]   w_pick;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [DATA_W-1:0]  w_sel_dout;
  logic               w_sel_empty;
  logic               w_sel_aempty;
  logic               w_sel_eod;
  logic [N_SRC-1:0]   w_rden;
  logic               w_rd;
  logic               w_in_grant;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (~src_aempty),
    .last  (r_last),
    .pick  (w_pick),
    .valid (w_pick_vld)
  );

  // r_last doubles as the granted index while a frame is open.
  always_comb begin
    w_sel_dout   = '0;
    w_sel_empty  = 1'b1;
    w_sel_aempty = 1'b1;
    w_sel_eod    = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_last == IDX_W'(i)) begin
        w_sel_dout   = src_dout[i*DATA_W +: DATA_W];
        w_sel_empty  = src_empty[i];
        w_sel_aempty = src_aempty[i];
        w_sel_eod    = src_eod[i];
      end
      if (w_pick[i]) w_pick_idx = IDX_W'(i);
    end
  end

  // DRAIN pulls bytes on its own so a broken source
  // cannot stall the TX port.
  always_comb begin
    w_rden = '0;
    unique case (r_state)
      S_GRANT: if (tx_fifo_rden && !w_sel_empty) w_rden = r_grant;
      S_DRAIN: if (!w_sel_empty) w_rden = r_grant;
      default: w_rden = '0;
    endcase
  end

  assign w_rd       = |w_rden;
  assign w_in_grant = (r_state == S_GRANT);

  assign src_rden       = w_rden;
  assign tx_fifo_dout   = w_in_grant ? w_sel_dout : '0;
  assign tx_fifo_empty  = w_in_grant ? w_sel_empty : 1'b1;
  assign tx_fifo_aempty = w_in_grant ? w_sel_aempty : 1'b1;
  assign tx_fifo_eod    = w_in_grant ? w_sel_eod : 1'b0;
  assign grant          = r_grant;
  assign busy           = r_busy;
  assign err_overlong   = r_err;

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_last     <= IDX_W'(N_SRC - 1);
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_grant    <= w_pick;
            r_last     <= w_pick_idx;
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_rd) begin
            if (r_byte_cnt != {CNT_W{1'b1}})
              r_byte_cnt <= r_byte_cnt + 1'b1;
            // EOD wins over the limit on the same byte.
            if (w_sel_eod) begin
              r_grant   <= '0;
              r_busy    <= 1'b0;
              r_gap_cnt <= GAP_LD;
              r_state   <= S_GAP;
            end else if (r_byte_cnt == LIM) begin
              r_err   <= 1'b1;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_rd && w_sel_eod) begin
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_gap_cnt <= GAP_LD;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
          if (r_gap_cnt == 4'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_tx_frame_arbiter.sv
// tb_rmii_tx_frame_arbiter: scoreboard bench for the frame arbiter.
// Source FIFOs are modelled as arrays; expected frame order comes from a queue model.
module tb_rmii_tx_frame_arbiter;

  localparam int N     = 3;
  localparam int W     = 8;
  localparam int MAXB  = 1536;
  localparam int GAP   = 2;
  localparam int DEPTH = 4096;

  logic           REF_CLK = 1'b0;
  logic           arst_n  = 1'b0;
  logic [N*W-1:0] src_dout;
  logic [N-1:0]   src_empty;
  logic [N-1:0]   src_aempty;
  logic [N-1:0]   src_eod;
  logic [N-1:0]   src_rden;
  logic [W-1:0]   tx_fifo_dout;
  logic           tx_fifo_empty;
  logic           tx_fifo_aempty;
  logic           tx_fifo_eod;
  logic           tx_fifo_rden = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           err_overlong;

  logic [7:0] mem  [N][DEPTH];
  logic       eodm [N][DEPTH];
  int         rp [N];
  int         wp [N];
  logic [N-1:0] hold = '0;
  logic       fifo_clr = 1'b0;
  int         rd_pct = 100;

  typedef struct {
    int src;
    int len;
    int seed;
    int off;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int nfr [N];
  int flen [N][4];
  int fseed [N][4];

  always #10 REF_CLK = ~REF_CLK;

  rmii_tx_frame_arbiter #(
    .N_SRC     (N),
    .DATA_W    (W),
    .MAX_BYTES (MAXB),
    .GAP_CYC   (GAP)
  ) dut (
    .REF_CLK        (REF_CLK),
    .arst_n         (arst_n),
    .src_dout       (src_dout),
    .src_empty      (src_empty),
    .src_aempty     (src_aempty),
    .src_eod        (src_eod),
    .src_rden       (src_rden),
    .tx_fifo_dout   (tx_fifo_dout),
    .tx_fifo_empty  (tx_fifo_empty),
    .tx_fifo_aempty (tx_fifo_aempty),
    .tx_fifo_eod    (tx_fifo_eod),
    .tx_fifo_rden   (tx_fifo_rden),
    .grant          (grant),
    .busy           (busy),
    .err_overlong   (err_overlong)
  );

  for (genvar i = 0; i < N; i++) begin : g_src
    assign src_empty[i]    = (rp[i] == wp[i]) || hold[i];
    assign src_aempty[i]   = src_empty[i];
    assign src_dout[i*W +: W] = mem[i][rp[i] % DEPTH];
    assign src_eod[i]      = eodm[i][rp[i] % DEPTH];
  end

  always @(posedge REF_CLK) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_clr) rp[i] <= 0;
      else if (src_rden[i]) rp[i] <= rp[i] + 1;
    end
  end

  initial forever begin
    @(posedge REF_CLK);
    #2 tx_fifo_rden = ($urandom_range(0, 99) < rd_pct);
  end

  function automatic logic [7:0] fb(int seed, int k);
    return 8'((seed >>> 3) + k * 13 + (k >>> 8) * 7);
  endfunction

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit           in_frame = 0;
  bit           prev_valid = 0;
  exp_t         cur;
  logic [N-1:0] oh;
  logic         ge;
  int n, gapc, fr_bad, data_bad, err_cnt, err_at;
  int idle_bad = 0;

  initial forever begin
    @(negedge REF_CLK);
    if (!arst_n) begin
      in_frame   = 0;
      prev_valid = 0;
    end else begin
      if (!in_frame && grant != '0) begin
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: got %b required none",
                   grant);
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $fatal(1);
        end
        cur = sbq.pop_front();
        oh  = N'(1) << cur.src;
        check("grant_src", 64'(grant), 64'(oh));
        if (prev_valid) check("gap_cycles", gapc, GAP + 1);
        in_frame = 1;
        n = 0; fr_bad = 0; data_bad = 0;
        err_cnt = 0; err_at = 0;
      end
      if (in_frame) begin
        ge = src_empty[cur.src];
        if (err_overlong) begin
          err_cnt++;
          err_at = n;
        end
        if (n < MAXB) begin
          if (grant !== oh || busy !== 1'b1 ||
              tx_fifo_empty !== ge ||
              tx_fifo_aempty !== src_aempty[cur.src] ||
              tx_fifo_eod !== src_eod[cur.src]) fr_bad++;
          if (!ge && tx_fifo_dout !== src_dout[cur.src*W +: W])
            fr_bad++;
          if (src_rden !== ((tx_fifo_rden && !ge) ? oh : '0))
            fr_bad++;
        end else begin
          if (busy !== 1'b1 || tx_fifo_empty !== 1'b1 ||
              tx_fifo_aempty !== 1'b1 || tx_fifo_eod !== 1'b0 ||
              tx_fifo_dout !== '0) fr_bad++;
          if (src_rden !== (!ge ? oh : '0)) fr_bad++;
        end
        if (src_rden[cur.src]) begin
          if (src_dout[cur.src*W +: W] !==
              fb(cur.seed, cur.off + n)) data_bad++;
          n++;
          if (src_eod[cur.src]) begin
            check("frame_len", n, cur.len);
            check("frame_data", data_bad, 0);
            check("frame_mux", fr_bad, 0);
            check("err_pulses", err_cnt, 64'(cur.len > MAXB));
            check("err_at_byte", err_at,
                  (cur.len > MAXB) ? MAXB : 0);
            in_frame   = 0;
            prev_valid = 1;
            gapc       = 0;
          end
        end
      end else begin
        gapc++;
        if (src_rden != '0 || busy !== 1'b0 ||
            err_overlong !== 1'b0 || tx_fifo_empty !== 1'b1 ||
            tx_fifo_aempty !== 1'b1 || tx_fifo_eod !== 1'b0 ||
            tx_fifo_dout !== '0) idle_bad++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int idle_snap;

  task automatic load_all();
    int left [N];
    int last;
    int tot;
    bit got;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      for (int f = 0; f < nfr[i]; f++) begin
        for (int k = 0; k < flen[i][f]; k++) begin
          mem[i][wp[i]]  = fb(fseed[i][f], k);
          eodm[i][wp[i]] = (k == flen[i][f] - 1);
          wp[i]++;
        end
      end
      left[i] = nfr[i];
      tot += nfr[i];
    end
    // Whole-frame round robin over sources holding frames.
    last = N - 1;
    for (int t = 0; t < tot; t++) begin
      got = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        int f;
        c = (last + k) % N;
        if (!got && left[c] > 0) begin
          f = nfr[c] - left[c];
          sbq.push_back('{src: c, len: flen[c][f],
                          seed: fseed[c][f], off: 0});
          left[c]--;
          last = c;
          got  = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    arst_n   = 1'b0;
    hold     = '0;
    fifo_clr = 1'b1;
    for (int i = 0; i < N; i++) wp[i] = 0;
    repeat (2) @(posedge REF_CLK);
    #1 fifo_clr = 1'b0;
  endtask

  task automatic chk_reset(string nm);
    check(nm,
      64'({grant, src_rden, busy, err_overlong, tx_fifo_empty,
           tx_fifo_aempty, tx_fifo_dout, tx_fifo_eod}),
      64'({N'(0), N'(0), 4'b0011, 8'h00, 1'b0}));
  endtask

  task automatic begin_test(bit late);
    int first;
    do_reset();
    idle_snap = idle_bad;
    if (!late) load_all();
    @(posedge REF_CLK);
    #1 arst_n = 1'b1;
    if (late) begin
      @(posedge REF_CLK);
      #1 load_all();
      first = sbq[0].src;
      @(posedge REF_CLK);
      #1 check("grant_latency", 64'(grant), 64'(N'(1) << first));
    end
  endtask

  task automatic end_test(string nm);
    int cyc;
    cyc = 0;
    while ((sbq.size() != 0 || in_frame) && cyc < 8000) begin
      @(negedge REF_CLK);
      cyc++;
    end
    repeat (4) @(negedge REF_CLK);
    check({nm, "_done"}, 64'(sbq.size() == 0 && !in_frame), 1);
    check({nm, "_idle"}, idle_bad - idle_snap, 0);
  endtask

  task automatic set_frames(int n0, int l0, int n1, int l1,
                            int n2, int l2);
    nfr[0] = n0; nfr[1] = n1; nfr[2] = n2;
    for (int f = 0; f < 4; f++) begin
      flen[0][f] = l0; flen[1][f] = l1; flen[2][f] = l2;
      for (int i = 0; i < N; i++) fseed[i][f] = $urandom;
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge REF_CLK);
    #1 chk_reset("reset_values");

    rd_pct = 100;
    set_frames(0, 0, 1, 64, 0, 0);
    begin_test(1);
    end_test("single");

    rd_pct = 90;
    set_frames(2, 64, 2, 64, 2, 64);
    begin_test(0);
    end_test("round_robin");

    for (int r = 0; r < 3; r++) begin
      rd_pct = $urandom_range(50, 100);
      set_frames(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
        nfr[i] = $urandom_range(1, 3);
        for (int f = 0; f < 4; f++)
          flen[i][f] = $urandom_range(2, 120);
      end
      begin_test(0);
      end_test("random");
    end

    rd_pct = 80;
    set_frames(1, 2000, 1, 64, 0, 0);
    begin_test(0);
    end_test("overlong");

    set_frames(1, 10, 0, 0, 1, 1536);
    begin_test(0);
    end_test("coincident");

    rd_pct = 100;
    set_frames(0, 0, 0, 0, 1, 64);
    begin_test(0);
    cyc = 0;
    while (rp[2] < 30 && cyc < 500) begin
      @(posedge REF_CLK);
      #1 cyc++;
    end
    check("underrun_reach", rp[2], 30);
    hold[2] = 1'b1;
    repeat (4) @(posedge REF_CLK);
    @(negedge REF_CLK);
    check("underrun_hold",
          64'({grant, src_rden, tx_fifo_empty}),
          64'({3'b100, 3'b000, 1'b1}));
    repeat (5) @(posedge REF_CLK);
    #1 hold[2] = 1'b0;
    end_test("underrun");

    rd_pct = 85;
    set_frames(1, 64, 1, 64, 0, 0);
    begin_test(0);
    cyc = 0;
    while (rp[0] < 20 && cyc < 500) begin
      @(posedge REF_CLK);
      #1 cyc++;
    end
    check("reset_reach", rp[0], 20);
    #2 arst_n = 1'b0;
    #1 chk_reset("reset_async");
    sbq.push_front('{src: 0, len: 44, seed: fseed[0][0],
                     off: 20});
    repeat (2) @(posedge REF_CLK);
    #1 arst_n = 1'b1;
    @(posedge REF_CLK);
    #1 check("regrant_src0", 64'(grant), 64'(3'b001));
    end_test("reset_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL time_limit: got timeout required finish");
    $fatal(1);
  end

endmodule

// File: doc/rmii_tx_frame_arbiter.md
Name: rmii_tx_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares one RMII_TX port between N_SRC FRAME_FIFO read sides. This is the building block for the 4-port hub: each PHY TX takes frames from the other three ports' RX FIFOs.
It sits between the FRAME_FIFO read ports, all in the REF_CLK domain of the target PHY, and one RMII_TX instance.
- Locks a grant for exactly one whole frame, delimited by EOD.
- Multiplexes data and flags to the TX engine.
- Drains overlong, EOD-less frames so a broken source cannot wedge the port.

Parameters:
N_SRC, 3, number of source FIFOs (2..8)
DATA_W, 8, FIFO data width
MAX_BYTES, 1536, byte reads per frame before the watchdog fires
GAP_CYC, 2, idle cycles presented to the TX engine between frames (1..15)

Ports:
REF_CLK  in  1  target PHY reference clock (50 MHz); sole clock
arst_n  in  1  asynchronous active-low reset
src_dout  in  N_SRC*DATA_W  source FIFO read data; source i occupies bits [i*DATA_W +: DATA_W]
src_empty  in  N_SRC  source FIFO empty flags
src_aempty  in  N_SRC  source FIFO almost-empty flags
src_eod  in  N_SRC  source EOD_out; high while the current dout is the last byte of a frame
src_rden  out  N_SRC  read enables to the source FIFOs
tx_fifo_dout  out  DATA_W  to RMII_TX fifo_dout
tx_fifo_empty  out  1  to RMII_TX fifo_empty
tx_fifo_aempty  out  1  to RMII_TX fifo_aempty
tx_fifo_eod  out  1  to RMII_TX fifo_EOD_out
tx_fifo_rden  in  1  from RMII_TX fifo_rden
grant  out  N_SRC  one-hot registered grant; all-zero when no grant
busy  out  1  high in GRANT or DRAIN
err_overlong  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- One clock (REF_CLK); reset is asynchronous and active-low (arst_n).
- Reset values:
  - state=IDLE; grant=0; src_rden=0; busy=0; err_overlong=0.
  - tx_fifo_empty=1, tx_fifo_aempty=1, tx_fifo_dout=0, tx_fifo_eod=0.
  - rr_last=N_SRC-1, so source 0 wins first; byte_cnt=0; gap_cnt=0.
- Eligibility: source i is eligible when src_aempty[i]=0.
- States: IDLE, GRANT, DRAIN, GAP.
- IDLE:
  - If any source is eligible, pick the first eligible index searching rr_last+1, rr_last+2, ... modulo N_SRC.
  - Register grant, set rr_last to that index, clear byte_cnt, go to GRANT.
  - Latency: eligible at cycle t gives grant and live mux at t+1.
  - With no eligible source, stay in IDLE.
- Mux, combinational from the registered grant:
  - In GRANT, the tx_fifo_* outputs equal the granted source's signals.
  - In all other states, tx_fifo_empty=1, tx_fifo_aempty=1, tx_fifo_eod=0, tx_fifo_dout=0.
- Read path in GRANT: src_rden[g] = tx_fifo_rden & ~src_empty[g]. All other src_rden bits are 0. tx_fifo_rden is ignored outside GRANT.
- A read event is src_rden[g]=1; each one increments byte_cnt (11 bits minimum, saturating).
- Frame end: a read event with src_eod[g]=1 goes to GAP and loads gap_cnt=GAP_CYC. grant is cleared on entry to GAP.
- Watchdog:
  - Fires on a read event with src_eod[g]=0 when byte_cnt==MAX_BYTES-1.
  - Pulses err_overlong and goes to DRAIN; grant stays held internally for DRAIN.
  - If EOD and the watchdog limit coincide, the frame completes normally and no error is raised.
- DRAIN:
  - src_rden[g] = ~src_empty[g], independent of the TX engine; the TX engine sees empty.
  - A read with src_eod[g]=1 goes to GAP.
  - A source that stays empty keeps DRAIN waiting; there is no timeout.
- GAP: decrement gap_cnt each cycle; at 1, go to IDLE. Arbitration resumes in IDLE.
- Underrun mid-frame (granted source empty in GRANT): no read is issued, the grant is held, and the empty flag passes through to the TX engine, which handles it.
- A source that becomes eligible while another holds the grant waits; fairness is guaranteed to within N_SRC-1 frames.
- busy = (state==GRANT)|(state==DRAIN), registered.
- Reset asserted mid-frame: immediate return to reset values. The partial frame stays in its FIFO and is sent as a new frame after reset.

Decomposition:
- Package rmii_arb_pkg holds:
  - the state enumeration (IDLE, GRANT, DRAIN, GAP, 2-bit);
  - the default MAX_BYTES (1536) and GAP_CYC (2);
  - the byte-counter width constant (11).
- One sub-module, rr_pick: purely combinational round-robin selector. Inputs are req[N_SRC] and last index; outputs are one-hot pick and valid. It is unit-testable in isolation.

Test Plan:
- Single source: src1 with a 64-byte frame (aempty deasserted, EOD on byte 64), TX reading every cycle -> grant=3'b010 one cycle later; exactly 64 reads on src_rden[1], no others; tx_fifo_eod seen on read 64; GAP for 2 cycles, then IDLE.
- Round-robin: all three sources hold two 64-byte frames from reset -> grant order 0,1,2,0,1,2; no frame interleaving; each frame is 64 contiguous reads.
- Overlong: src0 streams 2000 bytes with EOD on byte 2000 -> err_overlong pulses on read 1536; DRAIN consumes bytes 1537..2000 with the TX engine seeing empty; next grant goes to a waiting src1.
- Coincident limit: frame whose EOD is on byte 1536 -> normal completion, err_overlong stays 0.
- Underrun/idle gating: src2 goes empty at byte 30 for 10 cycles mid-frame -> no src_rden during the gap, grant held, tx_fifo_empty=1 mirrored, frame resumes; TX rden pulses in IDLE or GAP produce no src_rden.
- Reset mid-frame: arst_n low at byte 20 of a src0 frame -> all outputs return to reset values asynchronously; after release, src0 is re-granted first.
